// File: rtl/pipe_out_fifo.sv
// First-word-fall-through buffer feeding an output-pipe endpoint: user logic pushes
// 16-bit words, the endpoint pops one per ep_read strobe and samples the head on ep_datain.
module pipe_out_fifo #(
  parameter int DEPTH        = 1024,
  parameter int AFULL_THRESH = DEPTH - 4,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic              ti_clk,
  input  logic              ti_reset,
  input  logic              wr_en,
  input  logic [15:0]       wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              ep_read,
  output logic [15:0]       ep_datain,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underrun,
  input  logic              clr_flags
);

  localparam logic [ADDR_W:0] FULL_LVL  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_LVL = AFULL_THRESH[ADDR_W:0];

  logic [15:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_empty;
  logic              r_full;
  logic              r_afull;
  logic              r_overflow;
  logic              r_underrun;

  logic              w_push;
  logic              w_pop;
  logic [ADDR_W:0]   w_level_nxt;

  // A pop frees a slot at the same edge, so a full FIFO still accepts a push paired with a pop.
  assign w_pop  = ep_read && !r_empty;
  assign w_push = wr_en && (!r_full || w_pop);

  // NOTE: defaulting w_level_nxt first keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + 1'b1;
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; only pointers and flags
  // define whether its contents are meaningful, and a resettable array would not map to RAM.
  always_ff @(posedge ti_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == FULL_LVL);
      r_afull <= (w_level_nxt >= AFULL_LVL);

      // Sticky error flags: a new error event wins over a concurrent clear.
      if (wr_en && !w_push) begin
        r_overflow <= 1'b1;
      end else if (clr_flags) begin
        r_overflow <= 1'b0;
      end
      if (ep_read && r_empty) begin
        r_underrun <= 1'b1;
      end else if (clr_flags) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign ep_datain   = r_empty ? 16'h0000 : r_mem[r_rd_ptr];
  assign empty       = r_empty;
  assign full        = r_full;
  assign almost_full = r_afull;
  assign level       = r_level;
  assign overflow    = r_overflow;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Bench for pipe_out_fifo (DEPTH=8): stimulus pushes accepted words into a queue,
// a negedge monitor compares head word, level and flags and pops on each accepted read.
module tb_pipe_out_fifo;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AW    = 3;

  logic          ti_clk = 1'b0;
  logic          ti_reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [15:0]   wr_data = '0;
  logic          ep_read = 1'b0;
  logic          clr_flags = 1'b0;
  logic          full, almost_full, empty, overflow, underrun;
  logic [15:0]   ep_datain;
  logic [AW:0]   level;

  always #5 ti_clk = ~ti_clk;

  pipe_out_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
    .ti_clk      (ti_clk),
    .ti_reset    (ti_reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .ep_read     (ep_read),
    .ep_datain   (ep_datain),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .underrun    (underrun),
    .clr_flags   (clr_flags)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_popped = 0;
  logic [15:0] q[$];
  bit          exp_ovf = 1'b0;
  bit          exp_unr = 1'b0;
  bit          mon_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: state is stable at the negedge; the inputs now applied act on the next edge.
  always @(negedge ti_clk) begin
    if (mon_en) begin
      check("level",       32'(level),       32'(q.size()));
      check("empty",       32'(empty),       32'(q.size() == 0));
      check("full",        32'(full),        32'(q.size() == DEPTH));
      check("almost_full", 32'(almost_full), 32'(q.size() >= AF));
      check("overflow",    32'(overflow),    32'(exp_ovf));
      check("underrun",    32'(underrun),    32'(exp_unr));
      check("ep_datain",   32'(ep_datain),   (q.size() > 0) ? 32'(q[0]) : 32'h0);
      if (ep_read && q.size() > 0) begin
        void'(q.pop_front());
        n_popped++;
      end
    end
  end

  // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit we, input logic [15:0] wd, input bit rd, input bit clr);
    bit acc, ovf_ev, unr_ev;
    acc    = we && (q.size() < DEPTH || (rd && q.size() > 0));
    ovf_ev = we && !acc;
    unr_ev = rd && (q.size() == 0);
    wr_en = we; wr_data = wd; ep_read = rd; clr_flags = clr;
    @(posedge ti_clk);
    #1;
    if (acc) q.push_back(wd);
    if (ovf_ev) exp_ovf = 1'b1; else if (clr) exp_ovf = 1'b0;
    if (unr_ev) exp_unr = 1'b1; else if (clr) exp_unr = 1'b0;
    wr_en = 1'b0; ep_read = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic do_reset(input bit busy);
    mon_en = 1'b0;
    ti_reset = 1'b1; wr_en = busy; wr_data = 16'hBEEF; ep_read = busy; clr_flags = 1'b0;
    @(posedge ti_clk);
    #1;
    ti_reset = 1'b0; wr_en = 1'b0; ep_read = 1'b0;
    q.delete(); exp_ovf = 1'b0; exp_unr = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    summary();
    $finish;
  end

  initial begin
    logic [15:0] last_word;
    int base, sent, cyc;

    // Reset and idle.
    do_reset(1'b0);
    do_reset(1'b0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_level", 32'(level), 32'h0);
    check("rst_datain", 32'(ep_datain), 32'h0);
    check("rst_flags", {29'h0, full, overflow, underrun}, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0, 1'b0);

    // FWFT latency and drain order.
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    check("fwft_first", 32'(ep_datain), 32'h1111);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("pop1_head", 32'(ep_datain), 32'h2222);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("pop2_head", 32'(ep_datain), 32'h3333);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("pop3_head", 32'(ep_datain), 32'h0);
    check("pop3_empty", 32'(empty), 32'h1);

    // Fill, almost_full/full thresholds, overflow, ordered drain.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b0);
      if (i == 4) check("afull_after5", 32'(almost_full), 32'h0);
      if (i == 5) check("afull_after6", 32'(almost_full), 32'h1);
      if (i == 6) check("full_after7", 32'(full), 32'h0);
    end
    check("full_after8", 32'(full), 32'h1);
    check("level_after8", 32'(level), 32'h8);
    step(1'b1, 16'h0008, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_level", 32'(level), 32'h8);
    for (int i = 0; i < 8; i++) begin
      check("drain_word", 32'(ep_datain), 32'(i));
      step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(empty), 32'h1);
    check("drain_no8", 32'(ep_datain), 32'h0);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 32'h0);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hAAAA, 1'b1, 1'b0);
    check("fullrw_level", 32'(level), 32'h8);
    check("fullrw_ovf", 32'(overflow), 32'h0);
    check("fullrw_head", 32'(ep_datain), 32'h0101);
    last_word = 16'h0;
    for (int i = 0; i < 8; i++) begin
      last_word = ep_datain;
      step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    check("fullrw_last", 32'(last_word), 32'hAAAA);

    // Push and pop together while empty: pop rejected, push kept.
    step(1'b1, 16'h5A5A, 1'b1, 1'b0);
    check("emptyrw_unr", 32'(underrun), 32'h1);
    check("emptyrw_level", 32'(level), 32'h1);
    check("emptyrw_head", 32'(ep_datain), 32'h5A5A);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    check("unr_clr", 32'(underrun), 32'h0);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    check("unr_set_wins", 32'(underrun), 32'h1);
    step(1'b0, 16'h0, 1'b0, 1'b1);

    // Streaming through 5 pointer wraps.
    base = n_popped;
    sent = 0;
    cyc  = 0;
    while ((sent < 40 || q.size() > 0) && cyc < 600) begin
      bit we, rd;
      we = (sent < 40) && (q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      rd = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      step(we, 16'h4000 + 16'(sent), rd, 1'b0);
      if (we) sent++;
      cyc++;
    end
    check("stream_words_out", 32'(n_popped - base), 32'd40);

    // Reset in the middle of a stream, with a concurrent push and read.
    for (int i = 0; i < 3; i++) step(1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0);
    do_reset(1'b1);
    check("midrst_level", 32'(level), 32'h0);
    check("midrst_empty", 32'(empty), 32'h1);
    check("midrst_datain", 32'(ep_datain), 32'h0);
    step(1'b1, 16'hC0DE, 1'b0, 1'b0);
    check("postrst_head", 32'(ep_datain), 32'hC0DE);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);

    mon_en = 1'b0;
    summary();
    $finish;
  end

endmodule
